clock_set_ctrl: RTL and testbench

Time-set and run controller for the 24-hour BCD clock core. It generates the core's per-second enable and runs a button-driven edit mode: RUN, SET_HR, SET_MIN. In edit mode it captures the current time, lets the user step hours and minutes, and commits the result to the core with a one-cycle load strobe. It sits between the front-panel button conditioning and the counter core.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/clock_set_ctrl_bcd2_inc.sv | 35 +++
 rtl/clock_set_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types and BCD limits for the 24-hour clock time-set
//                controller and its BCD incrementer.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

   // Controller state; the value doubles as the encoding on the mode output
   // for the three user-visible states.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      LOAD    = 2'd3
   } mode_t;

   // Largest legal BCD digits for hours (23) and minutes (59)
   localparam logic [3:0] HR_MAX_MS  = 4'd2;
   localparam logic [3:0] HR_MAX_LS  = 4'd3;
   localparam logic [3:0] MIN_MAX_MS = 4'd5;
   localparam logic [3:0] MIN_MAX_LS = 4'd9;

endpackage : clock_pkg
`default_nettype wire

// File: rtl/clock_set_ctrl_bcd2_inc.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_inc
//  Description : Combinational two-digit BCD incrementer. Steps the value by
//                one, carrying from the units digit at 9 and wrapping to 00
//                once the value equals MAX_MS:MAX_LS.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2_inc
   import clock_pkg::*;
#(
   parameter logic [3:0] MAX_MS = HR_MAX_MS,
   parameter logic [3:0] MAX_LS = HR_MAX_LS
) (
   input  logic [3:0] ms,
   input  logic [3:0] ls,
   output logic [3:0] ms_next,
   output logic [3:0] ls_next
);

   // Wrap at the maximum first; otherwise carry out of the units digit at 9
   always_comb begin
      ms_next = ms;
      ls_next = ls + 4'd1;
      if ((ms == MAX_MS) && (ls == MAX_LS)) begin
         ms_next = 4'd0;
         ls_next = 4'd0;
      end else if (ls >= 4'd9) begin
         ms_next = ms + 4'd1;
         ls_next = 4'd0;
      end
   end

endmodule : bcd2_inc
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : Run/edit controller for the 24-hour BCD clock core. Produces
//                the per-second count enable and a button-driven time-set
//                mode that commits the edited time with a one-cycle load.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1,
   parameter int TIMEOUT_SEC   = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic [3:0] cur_ms_hr,
   input  logic [3:0] cur_ls_hr,
   input  logic [3:0] cur_ms_min,
   input  logic [3:0] cur_ls_min,
   output logic       run_en,
   output logic       load,
   output logic [3:0] ld_ms_hr,
   output logic [3:0] ld_ls_hr,
   output logic [3:0] ld_ms_min,
   output logic [3:0] ld_ls_min,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int TW = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC + 1) : 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_SEC - 1);

   localparam logic [1:0] ST_RUN     = RUN;
   localparam logic [1:0] ST_SET_HR  = SET_HR;
   localparam logic [1:0] ST_SET_MIN = SET_MIN;
   localparam logic [1:0] ST_LOAD    = LOAD;

   logic [1:0]    state;
   logic [1:0]    next_state;
   logic [PW-1:0] pre_cnt;
   logic [TW-1:0] tout_cnt;
   logic          btn_mode_q;
   logic          btn_inc_q;
   logic          mode_edge;
   logic          inc_edge;
   logic          sec_tick;
   logic          timed_out;
   logic          in_set;
   logic          next_in_set;

   logic [3:0] edit_ms_hr;
   logic [3:0] edit_ls_hr;
   logic [3:0] edit_ms_min;
   logic [3:0] edit_ls_min;
   logic [3:0] hr_ms_next;
   logic [3:0] hr_ls_next;
   logic [3:0] min_ms_next;
   logic [3:0] min_ls_next;

   // Mode has priority: an inc edge coinciding with a mode edge is dropped
   assign mode_edge   = btn_mode & ~btn_mode_q;
   assign inc_edge    = btn_inc & ~btn_inc_q & ~mode_edge;
   assign sec_tick    = (pre_cnt == PRE_LAST);
   assign in_set      = (state == ST_SET_HR) || (state == ST_SET_MIN);
   assign next_in_set = (next_state == ST_SET_HR) || (next_state == ST_SET_MIN);
   // The tick that would carry the count to TIMEOUT_SEC abandons the edit
   assign timed_out   = in_set && sec_tick && !inc_edge && (tout_cnt == TO_LAST);

   bcd2_inc #(
      .MAX_MS (HR_MAX_MS),
      .MAX_LS (HR_MAX_LS)
   ) u_hr_inc (
      .ms      (edit_ms_hr),
      .ls      (edit_ls_hr),
      .ms_next (hr_ms_next),
      .ls_next (hr_ls_next)
   );

   bcd2_inc #(
      .MAX_MS (MIN_MAX_MS),
      .MAX_LS (MIN_MAX_LS)
   ) u_min_inc (
      .ms      (edit_ms_min),
      .ls      (edit_ls_min),
      .ms_next (min_ms_next),
      .ls_next (min_ls_next)
   );

   // Next-state decode for the run/edit sequence
   always_comb begin
      next_state = state;
      case (state)
         ST_RUN: begin
            if (mode_edge) next_state = ST_SET_HR;
         end
         ST_SET_HR: begin
            if (mode_edge)      next_state = ST_SET_MIN;
            else if (timed_out) next_state = ST_RUN;
         end
         ST_SET_MIN: begin
            if (mode_edge)      next_state = ST_LOAD;
            else if (timed_out) next_state = ST_RUN;
         end
         default: next_state = ST_RUN;
      endcase
   end

   // State register and button history; history resets high so a button
   // held through reset does not register as a press
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_RUN;
         btn_mode_q <= 1'b1;
         btn_inc_q  <= 1'b1;
      end else begin
         state      <= next_state;
         btn_mode_q <= btn_mode;
         btn_inc_q  <= btn_inc;
      end
   end

   // Second prescaler: free-running, held at zero through the load cycle so
   // the first second after a commit is a full second
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt <= '0;
      end else if ((state == ST_LOAD) || sec_tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Inactivity counter in whole seconds while editing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tout_cnt <= '0;
      end else if ((next_state != state) || mode_edge || inc_edge) begin
         tout_cnt <= '0;
      end else if (in_set && sec_tick) begin
         tout_cnt <= tout_cnt + 1'b1;
      end
   end

   // Edit registers: snapshot of the core on entry, then stepped per field
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edit_ms_hr  <= 4'd0;
         edit_ls_hr  <= 4'd0;
         edit_ms_min <= 4'd0;
         edit_ls_min <= 4'd0;
      end else if ((state == ST_RUN) && mode_edge) begin
         edit_ms_hr  <= cur_ms_hr;
         edit_ls_hr  <= cur_ls_hr;
         edit_ms_min <= cur_ms_min;
         edit_ls_min <= cur_ls_min;
      end else if ((state == ST_SET_HR) && inc_edge) begin
         edit_ms_hr  <= hr_ms_next;
         edit_ls_hr  <= hr_ls_next;
      end else if ((state == ST_SET_MIN) && inc_edge) begin
         edit_ms_min <= min_ms_next;
         edit_ls_min <= min_ls_next;
      end
   end

   // Registered outputs, all derived from the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_en    <= 1'b0;
         load      <= 1'b0;
         ld_ms_hr  <= 4'd0;
         ld_ls_hr  <= 4'd0;
         ld_ms_min <= 4'd0;
         ld_ls_min <= 4'd0;
         mode      <= ST_RUN;
         blink     <= 1'b0;
      end else begin
         run_en <= (state == ST_RUN) && (next_state == ST_RUN) && sec_tick;
         load   <= (next_state == ST_LOAD);
         mode   <= (next_state == ST_LOAD) ? ST_RUN : next_state;
         if (next_state == ST_LOAD) begin
            ld_ms_hr  <= edit_ms_hr;
            ld_ls_hr  <= edit_ls_hr;
            ld_ms_min <= edit_ms_min;
            ld_ls_min <= edit_ls_min;
         end
         if (!next_in_set || (next_state != state)) begin
            blink <= 1'b0;
         end else if (sec_tick) begin
            blink <= ~blink;
         end
      end
   end

endmodule : clock_set_ctrl
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_ctrl
//  Description : Self-checking bench for clock_set_ctrl. Two instances (the
//                default 1 tick/s, 30 s timeout and a 4 tick/s, 3 s timeout)
//                share stimulus and are compared every cycle against a
//                time-of-day reference model; directed scenarios pin the
//                model with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic btn_mode = 1'b0;
   logic btn_inc = 1'b0;
   int   cur_h = 0;
   int   cur_m = 0;

   wire [3:0] c_ms_hr  = 4'(cur_h / 10);
   wire [3:0] c_ls_hr  = 4'(cur_h % 10);
   wire [3:0] c_ms_min = 4'(cur_m / 10);
   wire [3:0] c_ls_min = 4'(cur_m % 10);

   wire        run0, load0, blink0, run1, load1, blink1;
   wire [1:0]  mode0, mode1;
   wire [15:0] ld0, ld1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clock_set_ctrl u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .cur_ms_hr  (c_ms_hr),
      .cur_ls_hr  (c_ls_hr),
      .cur_ms_min (c_ms_min),
      .cur_ls_min (c_ls_min),
      .run_en     (run0),
      .load       (load0),
      .ld_ms_hr   (ld0[15:12]),
      .ld_ls_hr   (ld0[11:8]),
      .ld_ms_min  (ld0[7:4]),
      .ld_ls_min  (ld0[3:0]),
      .mode       (mode0),
      .blink      (blink0)
   );

   clock_set_ctrl #(
      .TICKS_PER_SEC (4),
      .TIMEOUT_SEC   (3)
   ) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .cur_ms_hr  (c_ms_hr),
      .cur_ls_hr  (c_ls_hr),
      .cur_ms_min (c_ms_min),
      .cur_ls_min (c_ls_min),
      .run_en     (run1),
      .load       (load1),
      .ld_ms_hr   (ld1[15:12]),
      .ld_ls_hr   (ld1[11:8]),
      .ld_ms_min  (ld1[7:4]),
      .ld_ls_min  (ld1[3:0]),
      .mode       (mode1),
      .blink      (blink1)
   );

   // ---------------- reference model (time of day as integers) ----------
   int TK   [2] = '{1, 4};
   int TOUT [2] = '{30, 3};
   int st [2];      // 0 run, 1 hours, 2 minutes, 3 commit
   int ph [2];      // position within the current second
   int idle [2];    // whole seconds without a press while editing
   int eh [2], em [2], lh [2], lm [2];
   int x_mode [2];
   bit x_run [2], x_load [2], x_blink [2];
   bit mq [2], iq [2];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int bcd_time(input int h, input int m);
      return (h / 10) * 4096 + (h % 10) * 256 + (m / 10) * 16 + (m % 10);
   endfunction

   task automatic model_reset(input int i);
      st[i] = 0; ph[i] = 0; idle[i] = 0;
      eh[i] = 0; em[i] = 0; lh[i] = 0; lm[i] = 0;
      x_mode[i] = 0; x_run[i] = 0; x_load[i] = 0; x_blink[i] = 0;
      mq[i] = 1; iq[i] = 1;
   endtask

   task automatic model_step(input int i);
      bit me, ie, tick;
      int ns;
      me   = btn_mode && !mq[i];
      ie   = btn_inc && !iq[i] && !me;
      tick = (ph[i] == TK[i] - 1);
      ns   = st[i];
      if (st[i] == 0) begin
         if (me) begin
            eh[i] = cur_h;
            em[i] = cur_m;
            ns    = 1;
         end
      end else if (st[i] == 3) begin
         ns = 0;
      end else begin
         if (me) begin
            ns = st[i] + 1;
         end else if (ie) begin
            if (st[i] == 1) eh[i] = (eh[i] + 1) % 24;
            else            em[i] = (em[i] + 1) % 60;
            idle[i] = 0;
         end else if (tick) begin
            if (idle[i] + 1 >= TOUT[i]) ns = 0;
            else                        idle[i]++;
         end
      end
      if (ns != st[i]) idle[i] = 0;
      x_run[i]  = (st[i] == 0) && (ns == 0) && tick;
      x_load[i] = (ns == 3);
      if (ns == 3) begin
         lh[i] = eh[i];
         lm[i] = em[i];
      end
      if (ns == 1 || ns == 2) begin
         if (ns != st[i]) x_blink[i] = 0;
         else if (tick)   x_blink[i] = !x_blink[i];
      end else begin
         x_blink[i] = 0;
      end
      x_mode[i] = (ns == 3) ? 0 : ns;
      ph[i]     = (st[i] == 3) ? 0 : (ph[i] + 1) % TK[i];
      mq[i]     = btn_mode;
      iq[i]     = btn_inc;
      st[i]     = ns;
   endtask

   // Advance the model on every edge, then compare both instances
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) model_reset(i);
         else       model_step(i);
      end
      #1;
      check("mode0",  int'(mode0),  x_mode[0]);
      check("run0",   int'(run0),   int'(x_run[0]));
      check("load0",  int'(load0),  int'(x_load[0]));
      check("blink0", int'(blink0), int'(x_blink[0]));
      check("ld0",    int'(ld0),    bcd_time(lh[0], lm[0]));
      check("mode1",  int'(mode1),  x_mode[1]);
      check("run1",   int'(run1),   int'(x_run[1]));
      check("load1",  int'(load1),  int'(x_load[1]));
      check("blink1", int'(blink1), int'(x_blink[1]));
      check("ld1",    int'(ld1),    bcd_time(lh[1], lm[1]));
   end

   // ---------------- stimulus helpers ------------------------------------
   task automatic press_mode();
      @(negedge clk) btn_mode = 1'b1;
      @(negedge clk) btn_mode = 1'b0;
   endtask

   task automatic press_inc();
      @(negedge clk) btn_inc = 1'b1;
      @(negedge clk) btn_inc = 1'b0;
   endtask

   task automatic set_time(input int h, input int m);
      @(negedge clk);
      cur_h = h;
      cur_m = m;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int quiet;

      // Reset release: default instance enables every cycle from the start
      repeat (3) @(negedge clk);
      check("rst_mode0", int'(mode0), 0);
      check("rst_ld0",   int'(ld0),   0);
      reset = 1'b0;
      @(negedge clk);
      check("first_run0", int'(run0),  1);
      check("first_run1", int'(run1),  0);
      check("first_load", int'(load0), 0);
      check("first_mode", int'(mode0), 0);

      // 22:58 -> hours +2 -> 00, minutes +1 -> 59, commit 00:59
      set_time(22, 58);
      press_mode();
      check("s1_mode_hr", int'(mode0), 1);
      check("s1_run_off", int'(run0),  0);
      press_inc();
      press_inc();
      check("s1_still_hr", int'(mode0), 1);
      press_mode();
      check("s1_mode_min", int'(mode0), 2);
      press_inc();
      press_mode();
      check("s1_load",    int'(load0), 1);
      check("s1_ld",      int'(ld0),   16'h0059);
      check("s1_run_ld",  int'(run0),  0);
      @(negedge clk);
      check("s1_load_end", int'(load0), 0);
      check("s1_mode_run", int'(mode0), 0);

      // 09:59 -> 10:00 through both carries
      set_time(9, 59);
      press_mode();
      press_inc();
      press_mode();
      press_inc();
      press_mode();
      check("s2_load", int'(load0), 1);
      check("s2_ld",   int'(ld0),   16'h1000);

      // No presses in hours: 4 tick/s, 3 s instance falls back to run
      repeat (3) @(negedge clk);
      press_mode();
      check("s3_mode_hr", int'(mode1), 1);
      n = 0;
      while (mode1 != 2'd0 && n < 20) begin
         @(negedge clk);
         n++;
         check("s3_no_load", int'(load1), 0);
      end
      check("s3_timeout_window", int'(n >= 9 && n <= 12), 1);
      repeat (30) @(negedge clk);
      check("s3_default_back", int'(mode0), 0);

      // Mode and inc together in hours: hour unchanged, move to minutes
      set_time(13, 27);
      press_mode();
      @(negedge clk);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      check("s4_mode_min", int'(mode0), 2);
      press_mode();
      check("s4_load", int'(load0), 1);
      check("s4_ld",   int'(ld0),   16'h1327);

      // Reset in minutes with mode held through release
      repeat (2) @(negedge clk);
      press_mode();
      press_mode();
      check("s5_in_min", int'(mode0), 2);
      reset    = 1'b1;
      btn_mode = 1'b1;
      repeat (2) @(negedge clk);
      check("s5_rst_mode",  int'(mode0),  0);
      check("s5_rst_ld",    int'(ld0),    0);
      check("s5_rst_blink", int'(blink0), 0);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("s5_no_edge", int'(mode0), 0);
         check("s5_no_load", int'(load0), 0);
      end
      btn_mode = 1'b0;

      // Randomised traffic with quiet stretches so timeouts occur
      quiet = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (quiet > 0) begin
            quiet--;
            btn_mode = 1'b0;
            btn_inc  = 1'b0;
         end else begin
            btn_mode = ($urandom_range(0, 9) == 0);
            btn_inc  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) quiet = $urandom_range(10, 40);
         end
         reset = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 15) == 0) begin
            cur_h = $urandom_range(0, 23);
            cur_m = $urandom_range(0, 59);
         end
      end
      @(negedge clk);
      reset    = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_clock_set_ctrl
`default_nettype wire
